// File: rtl/simple_cpu2_pkg.sv
// Shared opcodes, FSM states and width constants for the simple_cpu2 core.
package simplecpu2_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 10;
  localparam int RIDX_W = 4;
  localparam int K8_W   = 8;
  localparam int NREGS  = 16;

  localparam logic [PC_W-1:0] PC_INC = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_LDC   = 4'd3,
    OP_SUB   = 4'd4,
    OP_JMPZ  = 4'd5,
    OP_ABS   = 4'd6
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2
  } state_e;

endpackage

// File: rtl/simple_cpu2_if.sv
// Memory bus between the execution unit (master) and the internal memories.
interface simplecpu2_if;
  import simplecpu2_pkg::*;

  logic [PC_W-1:0]   imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic [K8_W-1:0]   dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_we;

  modport master (
    output imem_addr, dmem_addr, dmem_wdata, dmem_we,
    input  imem_data, dmem_rdata
  );

  modport slave (
    input  imem_addr, dmem_addr, dmem_wdata, dmem_we,
    output imem_data, dmem_rdata
  );

endinterface

// File: rtl/simple_cpu2_execunit.sv
// Fetch/decode/execute sequencer with register bank; ABS datapath built only under SIMPLECPU2_ABS_EN.
module simplecpu2_execunit
  import simplecpu2_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  simplecpu2_if.master    bus,
  output logic [PC_W-1:0] pc
);

  state_e            state_r;
  logic [DATA_W-1:0] ir_r, a_r, b_r;
  opcode_e           op_s;
  logic [RIDX_W-1:0] rd_s, rs1_s, rs2_s, ra_s;
  logic [K8_W-1:0]   k8_s;
  logic [DATA_W-1:0] rf_a_s, rf_b_s, wdata_s;
  logic              rf_we_s, dmem_we_s;
  logic [PC_W-1:0]   pc_next_s;

  // Field split; STORE, JMPZ and ABS take operand A from rd instead of rs1
  always_comb begin
    op_s  = opcode_e'(ir_r[15:12]);
    rd_s  = ir_r[11:8];
    k8_s  = ir_r[7:0];
    rs1_s = ir_r[7:4];
    rs2_s = ir_r[3:0];
    if (op_s == OP_STORE || op_s == OP_JMPZ || op_s == OP_ABS) begin
      ra_s = rd_s;
    end else begin
      ra_s = rs1_s;
    end
  end

  // Execute-cycle write enables, write data and next pc
  always_comb begin
    rf_we_s   = 1'b0;
    dmem_we_s = 1'b0;
    wdata_s   = {DATA_W{1'b0}};
    pc_next_s = pc + PC_INC;
    if (state_r == ST_EXECUTE) begin
      case (op_s)
        OP_LOAD:  begin rf_we_s = 1'b1; wdata_s = bus.dmem_rdata; end
        OP_STORE: dmem_we_s = 1'b1;
        OP_ADD:   begin rf_we_s = 1'b1; wdata_s = a_r + b_r; end
        OP_LDC:   begin rf_we_s = 1'b1; wdata_s = {{(DATA_W-K8_W){1'b0}}, k8_s}; end
        OP_SUB:   begin rf_we_s = 1'b1; wdata_s = a_r - b_r; end
        OP_JMPZ: begin
          if (a_r == {DATA_W{1'b0}}) begin
            pc_next_s = pc + {{(PC_W-K8_W){k8_s[K8_W-1]}}, k8_s};
          end else begin
            pc_next_s = pc + PC_INC;
          end
        end
`ifdef SIMPLECPU2_ABS_EN
        OP_ABS: begin
          rf_we_s = 1'b1;
          if (a_r[DATA_W-1]) begin
            wdata_s = {DATA_W{1'b0}} - a_r;
          end else begin
            wdata_s = a_r;
          end
        end
`endif
        default: rf_we_s = 1'b0;
      endcase
    end else begin
      rf_we_s = 1'b0;
    end
  end

  // Async reset drops the FSM to FETCH at once, which also kills any pending write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FETCH;
      ir_r    <= {DATA_W{1'b0}};
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      pc      <= {PC_W{1'b0}};
    end else begin
      case (state_r)
        ST_FETCH: begin
          ir_r    <= bus.imem_data;
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          a_r     <= rf_a_s;
          b_r     <= rf_b_s;
          state_r <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          pc      <= pc_next_s;
          state_r <= ST_FETCH;
        end
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  regbank RegBank (
    .clk     (clk),
    .raddr_a (ra_s),
    .raddr_b (rs2_s),
    .we      (rf_we_s),
    .waddr   (rd_s),
    .wdata   (wdata_s),
    .rdata_a (rf_a_s),
    .rdata_b (rf_b_s)
  );

  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = k8_s;
  assign bus.dmem_wdata = a_r;
  assign bus.dmem_we    = dmem_we_s;

endmodule

// File: rtl/simple_cpu2_mem.sv
// Unreset word memory: combinational read, synchronous write.
module simplecpu2_mem #(
  parameter int DEPTH = 256,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_array [DEPTH];

  assign rdata = mem_array[addr];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
  end

endmodule

// File: rtl/simple_cpu2_regbank.sv
// 16x16 register file: two combinational read ports, one synchronous write port, not reset.
module regbank
  import simplecpu2_pkg::*;
(
  input  logic              clk,
  input  logic [RIDX_W-1:0] raddr_a,
  input  logic [RIDX_W-1:0] raddr_b,
  input  logic              we,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  // Register write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/simple_cpu2.sv
// simple_cpu2 top: execution unit plus internal instruction and data memories.
// Define SIMPLECPU2_ABS_EN to enable the ABS instruction (opcode 6).
module simple_cpu2 #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 256,
  parameter int DATA_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc
);

  simplecpu2_if bus ();

  simplecpu2_mem #(.DEPTH(IMEM_DEPTH), .W(DATA_W)) instmem (
    .clk   (clk),
    .addr  (bus.imem_addr),
    .we    (1'b0),
    .wdata ({DATA_W{1'b0}}),
    .rdata (bus.imem_data)
  );

  simplecpu2_mem #(.DEPTH(DMEM_DEPTH), .W(DATA_W)) datamemory (
    .clk   (clk),
    .addr  (bus.dmem_addr),
    .we    (bus.dmem_we),
    .wdata (bus.dmem_wdata),
    .rdata (bus.dmem_rdata)
  );

  simplecpu2_execunit execunit (
    .clk (clk),
    .rst (rst),
    .bus (bus.master),
    .pc  (pc)
  );

endmodule

// File: tb/tb_simple_cpu2.sv
// Self-checking bench for simple_cpu2: instruction-level model compared every cycle plus directed programs.
`timescale 1ns/1ps
module tb_simple_cpu2;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pc;

  simple_cpu2 dut (.clk(clk), .rst(rst), .pc(pc));

  always #5 clk = ~clk;

  logic [15:0] m_imem [1024];
  logic [15:0] m_dmem [256];
  logic [15:0] m_reg  [16];
  int          m_pc, m_last_addr, cyc;
  bit          active;
  int          n_checks, n_fail;
  logic [15:0] prog [$];

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // ISA-level model: one call retires one instruction
  function automatic void model_step();
    logic [15:0] ir;
    int op, rd, rs1, rs2, k8, v, off;
    ir  = m_imem[m_pc];
    op  = int'(ir[15:12]);
    rd  = int'(ir[11:8]);
    k8  = int'(ir[7:0]);
    rs1 = int'(ir[7:4]);
    rs2 = int'(ir[3:0]);
    m_last_addr = k8;
    case (op)
      0: m_reg[rd] = m_dmem[k8];
      1: m_dmem[k8] = m_reg[rd];
      2: m_reg[rd] = 16'((int'(m_reg[rs1]) + int'(m_reg[rs2])) % 65536);
      3: m_reg[rd] = 16'(k8);
      4: m_reg[rd] = 16'((int'(m_reg[rs1]) - int'(m_reg[rs2]) + 65536) % 65536);
      6: begin
`ifdef SIMPLECPU2_ABS_EN
        v = int'(m_reg[rd]);
        if (v >= 32768) v = 65536 - v;
        m_reg[rd] = 16'(v % 65536);
`endif
      end
      default: ;
    endcase
    if (op == 5 && m_reg[rd] == 16'h0000) begin
      off  = (k8 >= 128) ? k8 - 256 : k8;
      m_pc = (m_pc + off + 1024) % 1024;
    end else begin
      m_pc = (m_pc + 1) % 1024;
    end
  endfunction

  // Compare process: pc every cycle, registers and touched data word per retired instruction
  always @(posedge clk) begin
    if (active) begin
      #1;
      cyc++;
      if (cyc % 3 == 0) begin
        model_step();
        for (int i = 0; i < 16; i++)
          chk($sformatf("reg%0d@cyc%0d", i, cyc), dut.execunit.RegBank.mem[i], m_reg[i]);
        chk($sformatf("dmem[%0d]@cyc%0d", m_last_addr, cyc),
            dut.datamemory.mem_array[m_last_addr], m_dmem[m_last_addr]);
      end
      chk($sformatf("pc@cyc%0d", cyc), 16'(pc), 16'(m_pc));
    end
  end

  task automatic put_i(input int a, input logic [15:0] w);
    m_imem[a] = w;
    dut.instmem.mem_array[a] = w;
  endtask

  task automatic put_d(input int a, input logic [15:0] w);
    m_dmem[a] = w;
    dut.datamemory.mem_array[a] = w;
  endtask

  task automatic put_r(input int a, input logic [15:0] w);
    m_reg[a] = w;
    dut.execunit.RegBank.mem[a] = w;
  endtask

  task automatic prep();
    for (int i = 0; i < 1024; i++) put_i(i, 16'hFFFF);
    for (int i = 0; i < 256; i++) put_d(i, 16'($urandom));
    for (int i = 0; i < 16; i++) put_r(i, 16'($urandom));
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) put_i(i, prog[i]);
  endtask

  task automatic do_reset();
    active = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    #2;
    m_pc = 0;
  endtask

  task automatic run_cont(input int n);
    active = 1'b1;
    repeat (3 * n) @(posedge clk);
    #2;
    active = 1'b0;
  endtask

  task automatic release_run(input int n);
    cyc = 0;
    rst = 1'b1;
    run_cont(n);
  endtask

  initial begin
    rst = 1'b0; active = 1'b0; n_checks = 0; n_fail = 0; cyc = 0; m_pc = 0;
    @(posedge clk);
    #2;

    // LOAD / ADD / STORE
    prep();
    put_d(5, 16'h008D); put_d(6, 16'h0065); put_d(7, 16'h0012);
    prog = '{16'h0005, 16'h0106, 16'h0207, 16'h2001, 16'h2002, 16'h1005};
    load_prog();
    release_run(6);
    chk("ldst_d5", dut.datamemory.mem_array[5], 16'h0104);
    chk("ldst_d5_model", m_dmem[5], 16'h0104);
    do_reset();

    // LDC / ADD, pc reaches 5 after 15 cycles
    prep();
    prog = '{16'h3001, 16'h3101, 16'h3201, 16'h2012, 16'h1000};
    load_prog();
    release_run(5);
    chk("ldc_d0", dut.datamemory.mem_array[0], 16'h0002);
    chk("ldc_pc", 16'(pc), 16'h0005);
    chk("ldc_cycles", 16'(cyc), 16'd15);
    do_reset();

    // SUB both operand orders
    prep();
    prog = '{16'h3101, 16'h3203, 16'h4021, 16'h1000};
    load_prog();
    release_run(4);
    chk("sub_d0", dut.datamemory.mem_array[0], 16'h0002);
    do_reset();
    prep();
    prog = '{16'h3101, 16'h3203, 16'h4012, 16'h1000};
    load_prog();
    release_run(4);
    chk("sub_neg_d0", dut.datamemory.mem_array[0], 16'hFFFE);
    chk("sub_neg_model", m_dmem[0], 16'hFFFE);
    do_reset();

    // JMPZ taken
    prep();
    prog = '{16'h3101, 16'h3202, 16'h3000, 16'h5002, 16'h1100, 16'h1200};
    load_prog();
    release_run(5);
    chk("jmpz_taken_d0", dut.datamemory.mem_array[0], 16'h0002);
    chk("jmpz_taken_pc", 16'(pc), 16'h0006);
    do_reset();

    // JMPZ not taken
    prep();
    prog = '{16'h3101, 16'h3202, 16'h3000, 16'h5102, 16'h1100, 16'h1200};
    load_prog();
    release_run(5);
    chk("jmpz_nt_d0_first", dut.datamemory.mem_array[0], 16'h0001);
    run_cont(1);
    chk("jmpz_nt_d0_final", dut.datamemory.mem_array[0], 16'h0002);
    do_reset();

    // Backward loop: 3 setup + 10 iterations of (ADD, JMPZ -1)
    prep();
    prog = '{16'h3000, 16'h3101, 16'h3200, 16'h2001, 16'h52FF};
    load_prog();
    release_run(23);
    chk("loop_r0", dut.execunit.RegBank.mem[0], 16'h000A);
    chk("loop_pc", 16'(pc), 16'h0003);
    chk("loop_model_r0", m_reg[0], 16'h000A);
    do_reset();

    // Self-loop with offset 0
    prep();
    prog = '{16'h3000, 16'h5000};
    load_prog();
    release_run(6);
    chk("selfloop_pc", 16'(pc), 16'h0001);
    do_reset();

    // pc wrap both directions: 1 - 2 -> 1023, 1023 + 1 -> 0
    prep();
    prog = '{16'h3000, 16'h50FE};
    load_prog();
    put_i(1023, 16'h3177);
    release_run(5);
    chk("wrap_pc", 16'(pc), 16'd1023);
    chk("wrap_r1", dut.execunit.RegBank.mem[1], 16'h0077);
    do_reset();

    // ABS: negative, 0x8000 and positive inputs
    prep();
    put_d(0, 16'hFFFF); put_d(1, 16'h8000);
    prog = '{16'h0100, 16'h6100, 16'h0201, 16'h6200, 16'h3305, 16'h6300};
    load_prog();
    release_run(6);
`ifdef SIMPLECPU2_ABS_EN
    chk("abs_r1", dut.execunit.RegBank.mem[1], 16'h0001);
`else
    chk("abs_r1", dut.execunit.RegBank.mem[1], 16'hFFFF);
`endif
    chk("abs_r2", dut.execunit.RegBank.mem[2], 16'h8000);
    chk("abs_r3", dut.execunit.RegBank.mem[3], 16'h0005);
    do_reset();

    // Reset during EXECUTE of a STORE suppresses the write
    prep();
    put_d(32, 16'h1234);
    prog = '{16'h3155, 16'h1120};
    load_prog();
    cyc = 0;
    rst = 1'b1;
    active = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    active = 1'b0;
    rst = 1'b0;
    m_pc = 0;
    @(posedge clk);
    #2;
    chk("rst_store_d32", dut.datamemory.mem_array[32], 16'h1234);
    chk("rst_store_pc", 16'(pc), 16'h0000);
    chk("rst_store_r1", dut.execunit.RegBank.mem[1], 16'h0055);
    release_run(2);
    chk("rst_rerun_d32", dut.datamemory.mem_array[32], 16'h0055);
    do_reset();

    // Randomized programs over the whole instruction memory
    for (int s = 0; s < 3; s++) begin
      prep();
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 3) == 0) put_r(i, 16'h0000);
      for (int i = 0; i < 1024; i++) begin
        int r;
        logic [3:0] op;
        r  = $urandom_range(0, 9);
        op = (r <= 6) ? 4'(r) : 4'($urandom_range(7, 15));
        put_i(i, {op, 12'($urandom)});
      end
      release_run(300);
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
